// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event scheduler: detects rising/falling edges per channel, holds them
// as pending events and hands them one at a time, round-robin, to a valid/ready consumer.
module edge_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] a_i,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [CH_W-1:0]   evt_ch_o,
  output logic              evt_rise_o,
  output logic [NUM_CH-1:0] ovf_o,
  input  logic              ovf_clr_i
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state;
  logic [NUM_CH-1:0] prev;
  logic [NUM_CH-1:0] rise_pend;
  logic [NUM_CH-1:0] fall_pend;
  logic [CH_W-1:0]   ptr;

  logic [NUM_CH-1:0] rise_det;
  logic [NUM_CH-1:0] fall_det;
  logic [NUM_CH-1:0] cand;
  logic [NUM_CH-1:0] rise_clr;
  logic [NUM_CH-1:0] fall_clr;
  logic [NUM_CH-1:0] ovf_new;
  logic              load;
  logic              found;
  logic              sel_rise;
  logic [CH_W-1:0]   sel_ch;
  logic [CH_W-1:0]   idx;

  assign rise_det    = ~prev & a_i;
  assign fall_det    = prev & ~a_i;
  assign cand        = rise_pend | fall_pend;
  assign load        = (state == ST_EMPTY) || evt_ready_i;
  assign evt_valid_o = (state == ST_FULL);

  // Round-robin search starting just after the last granted channel. Only registered
  // pending state is considered; this cycle's detections become eligible next cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    found    = 1'b0;
    sel_ch   = '0;
    sel_rise = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_W'((int'(ptr) + k) % NUM_CH);
      if (!found && cand[idx]) begin
        found  = 1'b1;
        sel_ch = idx;
        // With both edges pending, the current level tells which came first:
        // low now means rise-then-fall, high means fall-then-rise.
        sel_rise = rise_pend[idx] & (~fall_pend[idx] | ~prev[idx]);
      end
    end
  end

  always_comb begin
    rise_clr = '0;
    fall_clr = '0;
    if (load && found) begin
      if (sel_rise) rise_clr[sel_ch] = 1'b1;
      else          fall_clr[sel_ch] = 1'b1;
    end
  end

  // A fresh edge only overflows if its pending bit survives this cycle; a same-cycle grant frees the slot.
  assign ovf_new = (rise_det & rise_pend & ~rise_clr) | (fall_det & fall_pend & ~fall_clr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_EMPTY;
      prev       <= '0;
      rise_pend  <= '0;
      fall_pend  <= '0;
      ptr        <= CH_W'(NUM_CH - 1);
      evt_ch_o   <= '0;
      evt_rise_o <= 1'b0;
      ovf_o      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
      prev      <= a_i;
      rise_pend <= (rise_pend & ~rise_clr) | rise_det;
      fall_pend <= (fall_pend & ~fall_clr) | fall_det;
      ovf_o     <= (ovf_o & ~{NUM_CH{ovf_clr_i}}) | ovf_new;
      if (load) begin
        if (found) begin
          state      <= ST_FULL;
          evt_ch_o   <= sel_ch;
          evt_rise_o <= sel_rise;
          ptr        <= sel_ch;
        end else begin
          state <= ST_EMPTY;
        end
      end
    end
  end

endmodule
